// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 multiplier (low 32 bits) that drives an external ALU
// using only LSR, ADD and LSL commands. Overflow reports a true product wider than 32 bits.
module alu_mul_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  input  logic [31:0] ALUOut,
  input  logic [3:0]  FlagsIn,
  output logic [31:0] Product,
  output logic        Overflow,
  output logic        Busy,
  output logic        Done
);

  localparam logic [4:0] FS_LSR = 5'b11100;
  localparam logic [4:0] FS_ADD = 5'b10100;
  localparam logic [4:0] FS_LSL = 5'b11011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHR,
    S_EVAL,
    S_ADD,
    S_SHL,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  count;
  logic        mbit;
  logic        mz;
  logic        lost;
  logic        first;

  // FlagsIn order is {Z,C,N,O}; only Z and C are used.
  logic unused_flags;
  assign unused_flags = ^FlagsIn[1:0];

  always_comb begin
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_FunSel = '0;
    ALU_WF     = 1'b0;
    case (state)
      S_SHR: begin
        ALU_A      = mplier;
        ALU_FunSel = FS_LSR;
        ALU_WF     = 1'b1;
      end
      S_ADD: begin
        ALU_A      = acc;
        ALU_B      = mcand;
        ALU_FunSel = FS_ADD;
        ALU_WF     = 1'b1;
      end
      S_SHL: begin
        ALU_A      = mcand;
        ALU_FunSel = FS_LSL;
        ALU_WF     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      mbit     <= 1'b0;
      mz       <= 1'b0;
      lost     <= 1'b0;
      first    <= 1'b0;
      Product  <= '0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            mcand    <= Multiplicand;
            mplier   <= Multiplier;
            acc      <= '0;
            count    <= '0;
            lost     <= 1'b0;
            Overflow <= 1'b0;
            first    <= 1'b1;
            Busy     <= 1'b1;
            state    <= S_SHR;
          end
        end
        S_SHR: begin
          // Flags still hold the carry of the previous iteration's LSL.
          if (!first) lost <= lost | FlagsIn[2];
          first  <= 1'b0;
          mplier <= ALUOut;
          state  <= S_EVAL;
        end
        S_EVAL: begin
          mbit  <= FlagsIn[2];
          mz    <= FlagsIn[3];
          state <= FlagsIn[2] ? S_ADD : S_SHL;
        end
        S_ADD: begin
          acc <= ALUOut;
          if (lost) Overflow <= 1'b1;
          state <= S_SHL;
        end
        S_SHL: begin
          mcand <= ALUOut;
          // mbit set means this iteration passed through ADD, so flags carry its carry-out.
          if (mbit) Overflow <= Overflow | FlagsIn[2];
          if (mz || count == 5'd31) begin
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            count <= count + 5'd1;
            state <= S_SHR;
          end
        end
        S_DONE: begin
          Product <= acc;
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU with a flag register, scoreboard of
// 64-bit reference products, and directed checks of command encodings and timing.
module tb_alu_mul_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Multiplicand = '0;
  logic [31:0] Multiplier = '0;
  logic [31:0] ALU_A, ALU_B, ALUOut, Product;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF, Overflow, Busy, Done;
  logic [3:0]  FlagsIn = '0;

  int errors = 0;
  int checks = 0;

  alu_mul_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ALUOut(ALUOut), .FlagsIn(FlagsIn),
    .Product(Product), .Overflow(Overflow), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Behavioural ALU: combinational result, flags {Z,C,N,O} registered when WF=1.
  logic [3:0] nflags;
  always_comb begin
    logic [32:0] t;
    t      = '0;
    ALUOut = '0;
    nflags = FlagsIn;
    case (ALU_FunSel)
      5'b11100: begin ALUOut = ALU_A >> 1; t[32] = ALU_A[0];  end
      5'b11011: begin ALUOut = ALU_A << 1; t[32] = ALU_A[31]; end
      5'b10100: begin t = {1'b0, ALU_A} + {1'b0, ALU_B}; ALUOut = t[31:0]; end
      default: ;
    endcase
    nflags[3] = (ALUOut == 32'd0);
    nflags[2] = t[32];
    nflags[1] = ALUOut[31];
    nflags[0] = (ALU_FunSel == 5'b10100) &&
                (ALU_A[31] == ALU_B[31]) && (ALUOut[31] != ALU_A[31]);
  end
  always @(posedge Clock) if (ALU_WF) FlagsIn <= nflags;

  typedef struct {
    logic [31:0] p;
    logic        ov;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [4:0]  tr_fs [0:255];
  logic [31:0] tr_a  [0:255];
  logic [31:0] tr_b  [0:255];
  logic        tr_wf [0:255];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] full;
    int it, adds;
    full = {32'd0, a} * {32'd0, b};
    it = 1;
    adds = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        it = i + 1;
        adds++;
      end
    end
    e.p   = full[31:0];
    e.ov  = |full[63:32];
    e.cyc = 3 * it + adds + 1;
    return e;
  endfunction

  task automatic record(input int n);
    if (n < 256) begin
      tr_fs[n] = ALU_FunSel;
      tr_a[n]  = ALU_A;
      tr_b[n]  = ALU_B;
      tr_wf[n] = ALU_WF;
    end
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_start);
    exp_t e;
    int n;
    bit busy_ok;
    @(negedge Clock);
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    sb.push_back(model(a, b));
    @(posedge Clock);
    n = 1;
    busy_ok = 1'b1;
    @(negedge Clock);
    Start        = 1'b0;
    Multiplicand = $urandom;
    Multiplier   = $urandom;
    while (Done !== 1'b1 && n < 200) begin
      record(n);
      if (Busy !== 1'b1) busy_ok = 1'b0;
      Start = mid_start && (n == 10);
      @(posedge Clock);
      n++;
      @(negedge Clock);
    end
    Start = 1'b0;
    record(n);
    if (Done !== 1'b1) begin
      check({tag, " done_timeout"}, 64'(Done), 64'd1);
    end else begin
      e = sb.pop_front();
      if (Busy !== 1'b1) busy_ok = 1'b0;
      check({tag, " done_cycle"}, 64'(n), 64'(e.cyc));
      check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
      Start = 1'b1;   // pulse during DONE, must be ignored
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
      check({tag, " done_pulse"}, 64'(Done), 64'd0);
      check({tag, " product"}, 64'(Product), 64'(e.p));
      check({tag, " overflow"}, 64'(Overflow), 64'(e.ov));
      @(posedge Clock);
      @(negedge Clock);
      check({tag, " idle_after"}, 64'(Busy), 64'd0);
    end
  endtask

  initial begin
    int k;
    #1;
    check("rst ALU_A", 64'(ALU_A), 64'd0);
    check("rst ALU_B", 64'(ALU_B), 64'd0);
    check("rst FunSel", 64'(ALU_FunSel), 64'd0);
    check("rst WF", 64'(ALU_WF), 64'd0);
    check("rst Product", 64'(Product), 64'd0);
    check("rst Overflow", 64'(Overflow), 64'd0);
    check("rst Busy", 64'(Busy), 64'd0);
    check("rst Done", 64'(Done), 64'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    do_mul("3x5", 32'd3, 32'd5, 1'b0);
    check("3x5 SHR fs", 64'(tr_fs[1]), 64'(5'b11100));
    check("3x5 SHR A", 64'(tr_a[1]), 64'd5);
    check("3x5 SHR wf", 64'(tr_wf[1]), 64'd1);
    check("3x5 EVAL fs", 64'(tr_fs[2]), 64'd0);
    check("3x5 EVAL wf", 64'(tr_wf[2]), 64'd0);
    check("3x5 ADD fs", 64'(tr_fs[3]), 64'(5'b10100));
    check("3x5 ADD A", 64'(tr_a[3]), 64'd0);
    check("3x5 ADD B", 64'(tr_b[3]), 64'd3);
    check("3x5 SHL fs", 64'(tr_fs[4]), 64'(5'b11011));
    check("3x5 SHL A", 64'(tr_a[4]), 64'd3);
    check("3x5 SHR2 A", 64'(tr_a[5]), 64'd2);
    check("3x5 SHL2 A", 64'(tr_a[7]), 64'd6);
    check("3x5 ADD2 A", 64'(tr_a[10]), 64'd3);
    check("3x5 ADD2 B", 64'(tr_b[10]), 64'd12);
    check("3x5 DONE fs", 64'(tr_fs[12]), 64'd0);

    do_mul("zero_mplier", 32'h12345678, 32'd0, 1'b0);
    do_mul("zero_mcand", 32'd0, 32'hA5A5A5A5, 1'b0);
    do_mul("ffff", 32'h0000FFFF, 32'h00010001, 1'b0);
    do_mul("lost16", 32'h00010000, 32'h00010000, 1'b0);
    do_mul("full32", 32'hFFFFFFFF, 32'h80000000, 1'b1);
    do_mul("addcarry", 32'hC0000000, 32'h00000003, 1'b0);
    do_mul("rand", 32'h0001_2345, 32'h0000_0ABC, 1'b0);

    // Reset in the middle of an ADD aborts the run silently.
    @(negedge Clock);
    Multiplicand = 32'd7;
    Multiplier   = 32'd9;
    Start        = 1'b1;
    sb.push_back(model(32'd7, 32'd9));
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    k = 0;
    while (ALU_FunSel !== 5'b10100 && k < 50) begin
      @(posedge Clock);
      @(negedge Clock);
      k++;
    end
    check("abort reached ADD", 64'(ALU_FunSel), 64'(5'b10100));
    Reset = 1'b0;
    void'(sb.pop_front());
    #1;
    check("abort ALU_A", 64'(ALU_A), 64'd0);
    check("abort ALU_B", 64'(ALU_B), 64'd0);
    check("abort FunSel", 64'(ALU_FunSel), 64'd0);
    check("abort WF", 64'(ALU_WF), 64'd0);
    check("abort Product", 64'(Product), 64'd0);
    check("abort Overflow", 64'(Overflow), 64'd0);
    check("abort Busy", 64'(Busy), 64'd0);
    check("abort Done", 64'(Done), 64'd0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    k = 0;
    repeat (12) begin
      @(posedge Clock);
      @(negedge Clock);
      if (Done === 1'b1 || Busy === 1'b1) k++;
    end
    check("abort no Done", 64'(k), 64'd0);

    do_mul("7x9", 32'd7, 32'd9, 1'b0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
